uart_tx_serializer: RTL and testbench

- Byte-wide to serial UART transmitter; directly downstream of the TX control FSM.
- Consumes the 8-bit `tx_data` / one-cycle `tx_start` pair and drives the `tx` serial line.
- Frame: 1 start bit, 8 data bits (LSB first), optional parity, 1 or 2 stop bits.
- Reports `tx_busy` and a one-cycle `tx_done` so upstream can pace bytes.

---
 rtl/uart_tx_serializer_pkg.sv | 9 +
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx_serializer.sv | 90 +++++++++
 tb/tb_uart_tx_serializer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// uart_pkg: shared UART types, data width and baud divider helper.
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int UART_DATA_BITS = 8;
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: byte request in, serial line and status out.
interface uart_tx_serializer_if;
  import uart_pkg::*;
  logic tx_start;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic tx;
  logic tx_busy;
  logic tx_done;
  modport master (output tx_start, tx_data, input tx, tx_busy, tx_done);
  modport slave (input tx_start, tx_data, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, tick in the last clock of each bit.
module uart_baud_tick #(
  parameter int BAUD_DIV = 868
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic enable,
  output logic tick,
  output logic [31:0] count
);
  assign tick = enable && count == 32'(BAUD_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clear || tick) count <= '0;
    else if (enable) count <= count + 32'd1;
  end
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8-bit UART transmitter, optional parity, 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clock,
  input logic reset,
  uart_tx_serializer_if.slave bus
);
  import uart_pkg::*;
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_serializer: BAUD_DIV must be at least 2");
  end
  tx_state_e state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0] idx;
  logic par_bit;
  logic stop_idx;
  logic last_stop;
  logic tick;
  logic [31:0] count;
  assign last_stop = stop_idx == 1'(STOP_BITS - 1);
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk(clock),
    .rst(reset),
    .clear(state == IDLE),
    .enable(state != IDLE),
    .tick(tick),
    .count(count)
  );
  // tx_done is registered one clock early so it lands on the final stop clock
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      par_bit <= 1'b0;
      stop_idx <= 1'b0;
      bus.tx <= 1'b1;
      bus.tx_busy <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= state == STOP && last_stop && count == 32'(BAUD_DIV - 2);
      case (state)
        IDLE: if (bus.tx_start) begin
          shreg <= bus.tx_data;
          par_bit <= ^bus.tx_data ^ (PAR_MODE == PAR_ODD);
          stop_idx <= 1'b0;
          state <= START;
          bus.tx <= 1'b0;
          bus.tx_busy <= 1'b1;
        end
        START: if (tick) begin
          idx <= '0;
          state <= DATA;
          bus.tx <= shreg[0];
        end
        DATA: if (tick) begin
          shreg <= shreg >> 1;
          idx <= idx + 3'd1;
          if (idx == 3'(UART_DATA_BITS - 1)) begin
            state <= (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
            bus.tx <= (PAR_MODE != PAR_NONE) ? par_bit : 1'b1;
          end else bus.tx <= shreg[1];
        end
        uart_pkg::PARITY: if (tick) begin
          state <= STOP;
          bus.tx <= 1'b1;
        end
        STOP: if (tick) begin
          if (last_stop) begin
            state <= IDLE;
            bus.tx_busy <= 1'b0;
          end else stop_idx <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: five configurations checked clock-by-clock against a frame-level model.
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int div_t[5] = '{10, 10, 10, 10, 868};
  int par_t[5] = '{0, 1, 2, 0, 0};
  int stp_t[5] = '{1, 1, 1, 2, 1};
  logic start[5];
  logic [7:0] data[5];
  logic tx_o[5];
  logic busy_o[5];
  logic done_o[5];
  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  uart_tx_serializer_if if2 ();
  uart_tx_serializer_if if3 ();
  uart_tx_serializer_if if4 ();
  assign if0.tx_start = start[0];
  assign if1.tx_start = start[1];
  assign if2.tx_start = start[2];
  assign if3.tx_start = start[3];
  assign if4.tx_start = start[4];
  assign if0.tx_data = data[0];
  assign if1.tx_data = data[1];
  assign if2.tx_data = data[2];
  assign if3.tx_data = data[3];
  assign if4.tx_data = data[4];
  assign tx_o = '{if0.tx, if1.tx, if2.tx, if3.tx, if4.tx};
  assign busy_o = '{if0.tx_busy, if1.tx_busy, if2.tx_busy, if3.tx_busy, if4.tx_busy};
  assign done_o = '{if0.tx_done, if1.tx_done, if2.tx_done, if3.tx_done, if4.tx_done};
  uart_tx_serializer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1))
    u0 (.clock(clk), .reset(rst), .bus(if0));
  uart_tx_serializer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1))
    u1 (.clock(clk), .reset(rst), .bus(if1));
  uart_tx_serializer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1))
    u2 (.clock(clk), .reset(rst), .bus(if2));
  uart_tx_serializer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(2))
    u3 (.clock(clk), .reset(rst), .bus(if3));
  uart_tx_serializer u4 (.clock(clk), .reset(rst), .bus(if4));

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  // line level of frame bit n: start, 8 data LSB first, optional parity, stop bits
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (n == 9 && par_t[i] != 0) return (par_t[i] == 1) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
    return 1'b1;
  endfunction

  function automatic int flen(input int i);
    return (10 + (par_t[i] != 0 ? 1 : 0) + stp_t[i] - 1) * div_t[i];
  endfunction

  task automatic go(input int i, input logic [7:0] d);
    start[i] = 1'b1;
    data[i] = d;
  endtask

  task automatic check_cycle(input int i, input logic [7:0] d, input int k);
    chk("tx", i, 32'(tx_o[i]), 32'(exp_bit(i, d, k / div_t[i])));
    chk("busy", i, 32'(busy_o[i]), 32'd1);
    chk("done", i, 32'(done_o[i]), 32'(k == flen(i) - 1));
  endtask

  task automatic check_idle(input int i);
    chk("idle_tx", i, 32'(tx_o[i]), 32'd1);
    chk("idle_busy", i, 32'(busy_o[i]), 32'd0);
    chk("idle_done", i, 32'(done_o[i]), 32'd0);
  endtask

  // call at the negedge where go() was issued; returns at the negedge of the idle clock after tx_done
  task automatic run_frame(input int i, input logic [7:0] d, input bit inject);
    int len;
    int n;
    logic [7:0] rx;
    len = flen(i);
    rx = '0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      start[i] = inject && (k == len / 2 || k == len - 1);
      data[i] = start[i] ? 8'hFF : 8'($urandom);
      check_cycle(i, d, k);
      n = k / div_t[i];
      if (k % div_t[i] == div_t[i] / 2 && n >= 1 && n <= 8) rx[n-1] = tx_o[i];
    end
    chk("rx_byte", i, 32'(rx), 32'(d));
    @(negedge clk);
    start[i] = 1'b0;
    check_idle(i);
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      start[i] = 1'b0;
      data[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) check_idle(i);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_idle(i);
    go(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0);
    go(1, 8'h07);
    run_frame(1, 8'h07, 1'b0);
    go(2, 8'h07);
    run_frame(2, 8'h07, 1'b0);
    go(3, 8'h00);
    run_frame(3, 8'h00, 1'b0);
    b = 8'($urandom);
    go(0, b);
    run_frame(0, b, 1'b1);
    go(0, 8'h3C);
    run_frame(0, 8'h3C, 1'b0);
    b = 8'h96;
    go(0, b);
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      check_cycle(0, b, k);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0);
    repeat (20) begin
      @(negedge clk);
      check_idle(0);
    end
    go(0, 8'h3C);
    run_frame(0, 8'h3C, 1'b0);
    rst = 1'b1;
    go(0, 8'h81);
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    check_idle(0);
    @(negedge clk);
    check_idle(0);
    for (int r = 0; r < 6; r++) begin
      int i;
      i = r % 4;
      b = 8'($urandom);
      go(i, b);
      run_frame(i, b, r[0]);
    end
    go(4, 8'h55);
    run_frame(4, 8'h55, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
